// File: rtl/dmac_pkg.sv
// Shared DMAC sizing constants, so the arbiter and the request FIFO
// instantiations agree on word width and queue depth.
package dmac_pkg;

  localparam int DMAC_DATA_SIZE          = 32;
  localparam int DMAC_REQ_FIFO_DEPTH_LG2 = 4;

endpackage

// File: rtl/dmac_fifo_mem.sv
// DEPTH x DATA_SIZE register array: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module dmac_fifo_mem #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH_LG2 = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [DEPTH_LG2-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [DEPTH_LG2-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmac_req_fifo.sv
// First-word-fall-through request FIFO between the DMAC channel arbiter and
// the AXI request engine; reports occupancy to the DMAC status logic.
module dmac_req_fifo
  import dmac_pkg::*;
#(
  parameter int DATA_SIZE = DMAC_DATA_SIZE,
  parameter int DEPTH_LG2 = DMAC_REQ_FIFO_DEPTH_LG2,
  parameter int AFULL_LVL = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DATA_SIZE-1:0] rd_data_o,
  output logic [DEPTH_LG2:0]   cnt_o,
  output logic                 afull_o,
  output logic                 empty_o
);

  localparam int                 PW        = DEPTH_LG2 + 1;
  localparam logic [PW-1:0]      PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]      DEPTH_CNT = PW'(1 << DEPTH_LG2);
  localparam logic [PW-1:0]      AFULL_CNT = PW'(AFULL_LVL);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cnt_q,  cnt_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Handshakes: a word moves on a side only in a cycle where valid and ready
  // are both high at the rising edge; neither ready depends on the other side.
  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[DEPTH_LG2-1:0] == rptr_q[DEPTH_LG2-1:0]) &&
                      (wptr_q[DEPTH_LG2] != rptr_q[DEPTH_LG2]);
  assign wr_ready_o = !full && !rst && !flush_i;
  assign rd_valid_o = !empty;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (rst || flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + PTR_ONE;
        2'b01:   cnt_d = cnt_q - PTR_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    cnt_q  <= cnt_d;
  end

  dmac_fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH_LG2 (DEPTH_LG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q[DEPTH_LG2-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rptr_q[DEPTH_LG2-1:0]),
    .rdata_o (rd_data_o)
  );

  assign cnt_o   = cnt_q;
  assign afull_o = (cnt_q >= AFULL_CNT);
  assign empty_o = (cnt_q == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_cnt_range:    assert property (@(posedge clk) disable iff (rst) cnt_q <= DEPTH_CNT);
  a_cnt_ptrs:     assert property (@(posedge clk) disable iff (rst) cnt_q == (wptr_q - rptr_q));

endmodule

// File: tb/tb_dmac_req_fifo.sv
// Directed bench for dmac_req_fifo: occupancy model plus expected-data queue,
// checked every cycle, with extra named checks at the interesting points.
module tb_dmac_req_fifo;

  localparam int DW    = 32;
  localparam int LG    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic [LG:0]   cnt_o;
  logic          afull_o;
  logic          empty_o;

  int            errors = 0;
  int            checks = 0;
  int            model_cnt = 0;
  logic [DW-1:0] exp_q[$];

  dmac_req_fifo #(
    .DATA_SIZE (DW),
    .DEPTH_LG2 (LG),
    .AFULL_LVL (AF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_data_i  (wr_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_data_o  (rd_data_o),
    .cnt_o      (cnt_o),
    .afull_o    (afull_o),
    .empty_o    (empty_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks mid-cycle against the model, then advances one clock edge.
  task automatic cycle();
    logic exp_wr_ready;
    logic exp_rd_valid;
    logic push_m;
    logic pop_m;
    #4;
    exp_wr_ready = (model_cnt < DEPTH) && !rst && !flush_i;
    exp_rd_valid = (model_cnt > 0);
    check("wr_ready", DW'(wr_ready_o), DW'(exp_wr_ready));
    check("rd_valid", DW'(rd_valid_o), DW'(exp_rd_valid));
    check("cnt",      DW'(cnt_o),      DW'(model_cnt));
    check("empty",    DW'(empty_o),    DW'(model_cnt == 0));
    check("afull",    DW'(afull_o),    DW'(model_cnt >= AF));
    push_m = wr_valid_i && exp_wr_ready;
    pop_m  = rd_ready_i && exp_rd_valid;
    if (pop_m) check("rd_data", rd_data_o, exp_q[0]);
    @(posedge clk);
    if (rst || flush_i) begin
      exp_q.delete();
    end else begin
      if (push_m) exp_q.push_back(wr_data_i);
      if (pop_m)  void'(exp_q.pop_front());
    end
    model_cnt = exp_q.size();
    #1;
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = base + DW'(i);
      cycle();
    end
    wr_valid_i = 1'b0;
  endtask

  initial begin
    // reset held, then idle
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    check("wr_ready_after_rst", DW'(wr_ready_o), DW'(1));
    repeat (10) cycle();

    // fill to full
    push_words(32'h1000, 16);
    check("fill_cnt",   DW'(cnt_o),      DW'(16));
    check("fill_afull", DW'(afull_o),    DW'(1));
    check("fill_ready", DW'(wr_ready_o), DW'(0));
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h1010;
    cycle();
    check("push17_blocked", DW'(cnt_o), DW'(16));

    // full with same-cycle pop: pop only, then the held push goes in
    rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    check("full_pop_cnt", DW'(cnt_o), DW'(15));
    #1;
    check("full_pop_ready", DW'(wr_ready_o), DW'(1));
    cycle();
    check("refill_cnt", DW'(cnt_o), DW'(16));
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b1;
    repeat (16) cycle();
    check("drain_empty", DW'(empty_o), DW'(1));

    // streaming across pointer wraps
    for (int i = 0; i < 40; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 32'h2000 + DW'(i);
      cycle();
      check("stream_cnt_le1", DW'(cnt_o <= 1), DW'(1));
    end
    wr_valid_i = 1'b0;
    repeat (2) cycle();
    check("stream_empty", DW'(empty_o), DW'(1));

    // random back-pressure
    for (int i = 0; i < 1000; i++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      rd_ready_i = 1'($urandom_range(0, 1));
      wr_data_i  = $urandom;
      cycle();
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b1;
    repeat (DEPTH + 1) cycle();
    check("rand_drain_empty", DW'(empty_o), DW'(1));

    // flush with a same-cycle push of 0xDEAD
    rd_ready_i = 1'b0;
    push_words(32'h3000, 5);
    check("pre_flush_cnt", DW'(cnt_o), DW'(5));
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hDEAD;
    cycle();
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    check("flush_cnt",   DW'(cnt_o),   DW'(0));
    check("flush_empty", DW'(empty_o), DW'(1));
    push_words(32'h3100, 2);
    rd_ready_i = 1'b1;
    repeat (3) cycle();

    // same scenario with reset
    rd_ready_i = 1'b0;
    push_words(32'h4000, 5);
    check("pre_rst_cnt", DW'(cnt_o), DW'(5));
    rst        = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hDEAD;
    cycle();
    rst        = 1'b0;
    wr_valid_i = 1'b0;
    check("rst_cnt",      DW'(cnt_o),      DW'(0));
    check("rst_empty",    DW'(empty_o),    DW'(1));
    check("rst_rd_valid", DW'(rd_valid_o), DW'(0));
    push_words(32'h4100, 2);
    rd_ready_i = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
